// File: rtl/dlsc_vga_ctrl.sv
// rtl/dlsc_vga_ctrl.sv - run-time controller for dlsc_vga_output
// Shadow/active modeline registers, output reset sequencing, DMA frame start with double buffering, statistics.
module dlsc_vga_ctrl #(
  parameter int XBITS      = 12,
  parameter int YBITS      = 12,
  parameter int ADDR       = 32,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_write,
  input  logic [3:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             vga_rst,
  output logic [XBITS-1:0] hdisp,
  output logic [XBITS-1:0] hsyncstart,
  output logic [XBITS-1:0] hsyncend,
  output logic [XBITS-1:0] htotal,
  output logic [YBITS-1:0] vdisp,
  output logic [YBITS-1:0] vsyncstart,
  output logic [YBITS-1:0] vsyncend,
  output logic [YBITS-1:0] vtotal,
  output logic [1:0]       pos_r,
  output logic [1:0]       pos_g,
  output logic [1:0]       pos_b,
  output logic [1:0]       pos_a,
  input  logic             frame_start,
  input  logic             frame_done,
  input  logic             underrun,
  output logic             dma_start,
  output logic [ADDR-1:0]  dma_addr,
  output logic             running,
  output logic             cfg_pending,
  output logic             flip_done,
  output logic [15:0]      frame_count,
  output logic [7:0]       underrun_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int CW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [3:0][XBITS-1:0]     hsh_q, hact_q;
  logic [3:0][YBITS-1:0]     vsh_q, vact_q;
  logic [7:0]                possh_q, posact_q;
  logic                      enable_q, enable_d;
  logic [ADDR-1:0]           addr_a_q, addr_b_q;
  logic                      front_q, front_d;
  logic                      flip_pend_q, flip_pend_d;
  logic                      flip_done_q, flip_done_d;
  logic                      dma_start_q, dma_start_d;
  logic                      pending_q, pending_d;
  logic                      sticky_q, sticky_d;
  logic [15:0]               fc_q, fc_d;
  logic [7:0]                uc_q, uc_d;
  logic                      commit;

  logic wr_h, wr_v, wr_pos, wr_en, wr_a, wr_b, wr_flip, wr_shadow;
  logic active_frame, frame_end, flip_req;

  // frame_start is informational only; the controller paces itself on frame_done.
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  assign wr_h      = cfg_write && (cfg_addr[3:2] == 2'b00);
  assign wr_v      = cfg_write && (cfg_addr[3:2] == 2'b01);
  assign wr_pos    = cfg_write && (cfg_addr == 4'd8);
  assign wr_en     = cfg_write && (cfg_addr == 4'd9);
  assign wr_a      = cfg_write && (cfg_addr == 4'd10);
  assign wr_b      = cfg_write && (cfg_addr == 4'd11);
  assign wr_flip   = cfg_write && (cfg_addr == 4'd12);
  assign wr_shadow = wr_h || wr_v || wr_pos;

  assign active_frame = (state_q == ST_RUN) || (state_q == ST_STOP);
  assign frame_end    = frame_done && active_frame;
  assign flip_req     = flip_pend_q || wr_flip;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enable_d    = wr_en ? cfg_wdata[0] : enable_q;
    front_d     = front_q;
    flip_pend_d = flip_req;
    flip_done_d = 1'b0;
    dma_start_d = 1'b0;
    sticky_d    = sticky_q;
    fc_d        = fc_q;
    uc_d        = uc_q;
    commit      = 1'b0;

    // An underrun coincident with frame_done belongs to the frame that is ending.
    if (frame_end) begin
      fc_d     = fc_q + 16'd1;
      sticky_d = 1'b0;
      if ((sticky_q || underrun) && (uc_q != 8'hFF)) begin
        uc_d = uc_q + 8'd1;
      end
    end else if (active_frame && underrun) begin
      sticky_d = 1'b1;
    end

    if ((frame_end || (state_q == ST_IDLE)) && flip_req) begin
      front_d     = ~front_q;
      flip_done_d = 1'b1;
      flip_pend_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        commit = 1'b1;
        if (enable_q) begin
          state_d     = ST_START;
          cnt_d       = '0;
          dma_start_d = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_done) begin
          if (!enable_d) begin
            state_d = ST_IDLE;
          end else begin
            dma_start_d = 1'b1;
            if (pending_q) begin
              state_d = ST_STOP;
            end
          end
        end else if (!enable_q || pending_q) begin
          state_d = ST_STOP;
        end
      end
      default: begin
        if (frame_done) begin
          commit = 1'b1;
          if (enable_d) begin
            state_d     = ST_START;
            cnt_d       = '0;
            dma_start_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    // A write landing on a commit cycle stays pending for the next commit.
    if (wr_shadow) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hsh_q       <= '0;
      hact_q      <= '0;
      vsh_q       <= '0;
      vact_q      <= '0;
      possh_q     <= '0;
      posact_q    <= '0;
      enable_q    <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      front_q     <= 1'b0;
      flip_pend_q <= 1'b0;
      flip_done_q <= 1'b0;
      dma_start_q <= 1'b0;
      pending_q   <= 1'b0;
      sticky_q    <= 1'b0;
      fc_q        <= '0;
      uc_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      front_q     <= front_d;
      flip_pend_q <= flip_pend_d;
      flip_done_q <= flip_done_d;
      dma_start_q <= dma_start_d;
      pending_q   <= pending_d;
      sticky_q    <= sticky_d;
      fc_q        <= fc_d;
      uc_q        <= uc_d;
      if (commit) begin
        hact_q   <= hsh_q;
        vact_q   <= vsh_q;
        posact_q <= possh_q;
      end
      if (wr_h) begin
        hsh_q[cfg_addr[1:0]] <= cfg_wdata[XBITS-1:0];
      end
      if (wr_v) begin
        vsh_q[cfg_addr[1:0]] <= cfg_wdata[YBITS-1:0];
      end
      if (wr_pos) begin
        possh_q <= cfg_wdata[7:0];
      end
      if (wr_a) begin
        addr_a_q <= cfg_wdata[ADDR-1:0];
      end
      if (wr_b) begin
        addr_b_q <= cfg_wdata[ADDR-1:0];
      end
    end
  end

  assign vga_rst        = (state_q == ST_IDLE) || (state_q == ST_START);
  assign running        = (state_q == ST_RUN);
  assign cfg_pending    = pending_q;
  assign flip_done      = flip_done_q;
  assign dma_start      = dma_start_q;
  assign dma_addr       = front_q ? addr_b_q : addr_a_q;
  assign frame_count    = fc_q;
  assign underrun_count = uc_q;

  assign hdisp      = hact_q[0];
  assign hsyncstart = hact_q[1];
  assign hsyncend   = hact_q[2];
  assign htotal     = hact_q[3];
  assign vdisp      = vact_q[0];
  assign vsyncstart = vact_q[1];
  assign vsyncend   = vact_q[2];
  assign vtotal     = vact_q[3];
  assign pos_r      = posact_q[1:0];
  assign pos_g      = posact_q[3:2];
  assign pos_b      = posact_q[5:4];
  assign pos_a      = posact_q[7:6];

endmodule

// File: tb/tb_dlsc_vga_ctrl.sv
// tb/tb_dlsc_vga_ctrl.sv - scoreboard bench for dlsc_vga_ctrl
// Frame-level model predicts each dma_start; a negedge monitor pops and compares.
module tb_dlsc_vga_ctrl;
  localparam int RST_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_write;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        vga_rst;
  logic [11:0] hdisp, hsyncstart, hsyncend, htotal;
  logic [11:0] vdisp, vsyncstart, vsyncend, vtotal;
  logic [1:0]  pos_r, pos_g, pos_b, pos_a;
  logic        frame_start, frame_done, underrun;
  logic        dma_start;
  logic [31:0] dma_addr;
  logic        running, cfg_pending, flip_done;
  logic [15:0] frame_count;
  logic [7:0]  underrun_count;

  always #5 clk = ~clk;

  dlsc_vga_ctrl #(.XBITS(12), .YBITS(12), .ADDR(32), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_write(cfg_write), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .vga_rst(vga_rst),
    .hdisp(hdisp), .hsyncstart(hsyncstart), .hsyncend(hsyncend), .htotal(htotal),
    .vdisp(vdisp), .vsyncstart(vsyncstart), .vsyncend(vsyncend), .vtotal(vtotal),
    .pos_r(pos_r), .pos_g(pos_g), .pos_b(pos_b), .pos_a(pos_a),
    .frame_start(frame_start), .frame_done(frame_done), .underrun(underrun),
    .dma_start(dma_start), .dma_addr(dma_addr), .running(running), .cfg_pending(cfg_pending),
    .flip_done(flip_done), .frame_count(frame_count), .underrun_count(underrun_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic        flip;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [31:0] m_a, m_b;
  logic        m_front, m_flip, m_sticky;
  int          m_frames, m_under;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cur_addr();
    return m_front ? m_b : m_a;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && dma_start === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dma_start_unexpected: got pulse at addr %0h expected none", dma_addr);
      end else begin
        e = exp_q.pop_front();
        chk("dma_addr", dma_addr, e.addr);
        chk("flip_done_with_dma", {31'b0, flip_done}, {31'b0, e.flip});
      end
    end
  end

  task automatic drive(input logic fd, input logic ur, input logic we, input logic [3:0] a,
                       input logic [31:0] d);
    frame_done = fd;
    underrun   = ur;
    cfg_write  = we;
    cfg_addr   = a;
    cfg_wdata  = d;
    @(posedge clk);
    #1;
    frame_done = 1'b0;
    underrun   = 1'b0;
    cfg_write  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d);
  endtask

  // Frame-level bookkeeping for one frame_done seen while the output is live.
  task automatic model_frame(input logic ur, input logic push_dma);
    exp_t e;
    m_frames++;
    if ((m_sticky || ur) && m_under < 255) m_under++;
    m_sticky = 1'b0;
    e.flip = 1'b0;
    if (m_flip) begin
      m_front = ~m_front;
      m_flip  = 1'b0;
      e.flip  = 1'b1;
    end
    e.addr = cur_addr();
    if (push_dma) exp_q.push_back(e);
  endtask

  task automatic start_seq();
    int n = 0;
    while (dma_start !== 1'b1 && n < 10) begin
      idle(1);
      n++;
    end
    chk("start_dma_seen", {31'b0, dma_start}, 32'd1);
    for (int k = 0; k < RST_CYCLES; k++) begin
      chk("vga_rst_during_start", {31'b0, vga_rst}, 32'd1);
      idle(1);
    end
    chk("vga_rst_after_start", {31'b0, vga_rst}, 32'd0);
    chk("running_after_start", {31'b0, running}, 32'd1);
  endtask

  task automatic enable_and_start();
    exp_t e;
    e.addr = cur_addr();
    e.flip = 1'b0;
    exp_q.push_back(e);
    wr(4'd9, 32'd1);
    start_seq();
  endtask

  task automatic plain_frame(input int gap);
    idle(gap);
    model_frame(1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    logic [11:0] new_h;
    logic [7:0]  pos;
    int          n;
    rst_n = 1'b0; cfg_write = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    frame_start = 1'b0; frame_done = 1'b0; underrun = 1'b0;
    m_a = '0; m_b = '0; m_front = 1'b0; m_flip = 1'b0; m_sticky = 1'b0;
    m_frames = 0; m_under = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_vga_rst", {31'b0, vga_rst}, 32'd1);
    chk("reset_running", {31'b0, running}, 32'd0);
    chk("reset_cfg_pending", {31'b0, cfg_pending}, 32'd0);
    chk("reset_frame_count", {16'b0, frame_count}, 32'd0);
    chk("reset_underrun_count", {24'b0, underrun_count}, 32'd0);
    chk("reset_hdisp", {20'b0, hdisp}, 32'd0);
    chk("reset_dma_start", {31'b0, dma_start}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    m_a = $urandom() & 32'hFFFF_F000;
    m_b = $urandom() | 32'h0000_1000;
    pos = 8'($urandom());
    wr(4'd10, m_a);
    wr(4'd11, m_b);
    wr(4'd1, 32'd656); wr(4'd2, 32'd752); wr(4'd3, 32'd800);
    wr(4'd4, 32'd480); wr(4'd5, 32'd490); wr(4'd6, 32'd492); wr(4'd7, 32'd525);
    wr(4'd8, {24'b0, pos});
    wr(4'd0, 32'd640);
    chk("idle_write_pending", {31'b0, cfg_pending}, 32'd1);
    chk("idle_hdisp_before_commit", {20'b0, hdisp}, 32'd0);
    idle(1);
    chk("idle_commit_pending", {31'b0, cfg_pending}, 32'd0);
    chk("hdisp", {20'b0, hdisp}, 32'd640);
    chk("hsyncstart", {20'b0, hsyncstart}, 32'd656);
    chk("hsyncend", {20'b0, hsyncend}, 32'd752);
    chk("htotal", {20'b0, htotal}, 32'd800);
    chk("vdisp", {20'b0, vdisp}, 32'd480);
    chk("vsyncstart", {20'b0, vsyncstart}, 32'd490);
    chk("vsyncend", {20'b0, vsyncend}, 32'd492);
    chk("vtotal", {20'b0, vtotal}, 32'd525);
    chk("pos", {24'b0, pos_a, pos_b, pos_g, pos_r}, {24'b0, pos});

    enable_and_start();
    chk("first_dma_consumed", exp_q.size(), 32'd0);

    for (int i = 0; i < 3; i++) plain_frame($urandom_range(5, 20));
    idle(1);
    chk("frame_count_3", {16'b0, frame_count}, 32'd3);
    chk("dma_all_consumed", exp_q.size(), 32'd0);

    // flip mid-frame, then flip coincident with frame_done
    idle(3);
    wr(4'd12, 32'd0);
    m_flip = 1'b1;
    plain_frame(4);
    chk("front_is_b", dma_addr, m_b);
    idle(5);
    m_flip = 1'b1;
    model_frame(1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 4'd12, 32'd0);
    chk("front_back_to_a", dma_addr, m_a);

    // two underruns in one frame, then one coincident with frame_done
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    idle(2);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    m_sticky = 1'b1;
    plain_frame(3);
    idle(4);
    model_frame(1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    plain_frame(3);
    idle(1);
    chk("underrun_count_2", {24'b0, underrun_count}, 32'd2);

    for (int f = 0; f < 40; f++) begin
      logic ur_fd, flip_fd;
      int gap;
      gap = $urandom_range(2, 6);
      for (int g = 0; g < gap; g++) begin
        logic ur, fl;
        ur = ($urandom_range(0, 4) == 0);
        fl = ($urandom_range(0, 7) == 0);
        if (ur) m_sticky = 1'b1;
        if (fl) m_flip = 1'b1;
        drive(1'b0, ur, fl, 4'd12, 32'd0);
      end
      ur_fd   = ($urandom_range(0, 2) == 0);
      flip_fd = ($urandom_range(0, 5) == 0);
      if (flip_fd) m_flip = 1'b1;
      model_frame(ur_fd, 1'b1);
      drive(1'b1, ur_fd, flip_fd, 4'd12, 32'd0);
    end
    idle(1);
    chk("random_frame_count", {16'b0, frame_count}, 32'(m_frames));
    chk("random_underrun_count", {24'b0, underrun_count}, 32'(m_under));

    m_a = $urandom();
    wr(4'd10, m_a);
    chk("addr_a_rewrite", dma_addr, cur_addr());
    m_b = $urandom();
    wr(4'd11, m_b);
    chk("addr_b_rewrite", dma_addr, cur_addr());

    // modeline change while running
    new_h = 12'($urandom_range(100, 2000));
    wr(4'd0, {20'b0, new_h});
    chk("run_write_pending", {31'b0, cfg_pending}, 32'd1);
    idle(2);
    chk("run_hdisp_held", {20'b0, hdisp}, 32'd640);
    chk("stopping_vga_rst", {31'b0, vga_rst}, 32'd0);
    model_frame(1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("restart_vga_rst", {31'b0, vga_rst}, 32'd1);
    chk("restart_hdisp", {20'b0, hdisp}, {20'b0, new_h});
    chk("restart_pending", {31'b0, cfg_pending}, 32'd0);
    start_seq();

    // disable via STOPPING, flip while idle, re-enable
    idle(3);
    wr(4'd9, 32'd0);
    idle(2);
    chk("disable_stopping_vga_rst", {31'b0, vga_rst}, 32'd0);
    chk("disable_stopping_running", {31'b0, running}, 32'd0);
    model_frame(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("disable_idle_vga_rst", {31'b0, vga_rst}, 32'd1);
    idle(3);
    wr(4'd12, 32'd0);
    n = 0;
    while (flip_done !== 1'b1 && n < 3) begin
      idle(1);
      n++;
    end
    chk("idle_flip_done", {31'b0, flip_done}, 32'd1);
    m_front = ~m_front;
    idle(1);
    chk("idle_flip_addr", dma_addr, cur_addr());
    enable_and_start();
    plain_frame(4);

    // disable coincident with frame_done goes straight to IDLE
    idle(3);
    model_frame(1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd9, 32'd0);
    chk("direct_idle_running", {31'b0, running}, 32'd0);
    chk("direct_idle_vga_rst", {31'b0, vga_rst}, 32'd1);
    idle(4);
    enable_and_start();

    for (int f = 0; f < 300; f++) begin
      idle(1);
      model_frame(1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 4'd0, 32'd0);
    end
    idle(1);
    chk("underrun_saturate", {24'b0, underrun_count}, 32'd255);
    chk("long_frame_count", {16'b0, frame_count}, 32'(m_frames & 16'hFFFF));
    chk("dma_queue_drained", exp_q.size(), 32'd0);

    // asynchronous reset mid-frame
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vga_rst", {31'b0, vga_rst}, 32'd1);
    chk("async_frame_count", {16'b0, frame_count}, 32'd0);
    chk("async_underrun_count", {24'b0, underrun_count}, 32'd0);
    chk("async_running", {31'b0, running}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);
    chk("post_reset_running", {31'b0, running}, 32'd0);
    chk("post_reset_vga_rst", {31'b0, vga_rst}, 32'd1);
    chk("post_reset_hdisp", {20'b0, hdisp}, 32'd0);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlsc_vga_ctrl.md
# dlsc_vga_ctrl

Run-time controller for `dlsc_vga_output`. It holds shadow copies of the modeline and pixel-position configuration and commits them only while the output block is held in reset, so the output never sees a mid-frame config change. It sequences the output block's reset, issues one DMA frame-start per frame with front/back buffer flipping, and accumulates frame and underrun statistics. It sits between the register bus and the `dlsc_vga_output` instance, and alongside the frame-fetch DMA.

## Interface
- XBITS, 12, horizontal config width
- YBITS, 12, vertical config width
- ADDR, 32, frame buffer address width
- RST_CYCLES, 4, cycles the output reset is held during START (≥2)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_write  in  1  register write strobe
- cfg_addr  in  4  register index
- cfg_wdata  in  32  write data
- vga_rst  out  1  reset to output block
- hdisp, hsyncstart, hsyncend, htotal  out  XBITS  active horizontal config
- vdisp, vsyncstart, vsyncend, vtotal  out  YBITS  active vertical config
- pos_r, pos_g, pos_b, pos_a  out  2  active byte positions
- frame_start, frame_done, underrun  in  1  status from output block
- dma_start  out  1  one-cycle pulse: fetch frame at dma_addr
- dma_addr  out  ADDR  front buffer base address
- running  out  1  state is RUN
- cfg_pending  out  1  shadow config not yet committed
- flip_done  out  1  one-cycle pulse on buffer swap
- frame_count  out  16  completed frames, wraps
- underrun_count  out  8  frames with underrun, saturates at 255

## Operation
- Registers:
  - 0–3: h config. 4–7: v config. Both use low bits of cfg_wdata.
  - 8: pos_r[1:0], pos_g[3:2], pos_b[5:4], pos_a[7:6].
  - 9: bit0 = enable.
  - 10: buffer A address. 11: buffer B address.
  - 12: flip request, write any value.
  - Unmapped index: ignored.
- Registers 0–8 write the shadow copy and set cfg_pending. Commit copies shadow → active outputs and clears cfg_pending. Commit occurs only in IDLE, or on exit from STOPPING.
- States:
  - IDLE: vga_rst=1; commit every cycle. enable=1 → START.
  - START: vga_rst=1 for RST_CYCLES cycles, counted from entry. dma_start pulses in the entry cycle. After the count, vga_rst=0 → RUN.
  - RUN: on frame_done, frame_count++ and pulse dma_start the next cycle. Exit: enable=0 or cfg_pending=1 → STOPPING.
  - STOPPING: vga_rst=0; wait for frame_done (counted as in RUN, no dma_start). Then commit and go to START if enable=1, else IDLE.
- Buffers:
  - front selects A (reset) or B; dma_addr = selected address register.
  - A flip request sets flip_pending. flip_pending is applied at the next frame_done in RUN/STOPPING, or immediately in IDLE: front toggles, flip_done pulses, flip_pending clears.
  - A flip request arriving in the same cycle as frame_done is applied at that frame_done.
- Underrun:
  - A sticky bit sets on underrun=1 in RUN/STOPPING.
  - At frame_done: sticky=1 → underrun_count++ (saturating); sticky clears.
  - underrun=1 in the same cycle as frame_done counts toward the frame just ending.
- Same-cycle events:
  - Config write in the same cycle as frame_done: shadow takes the write; state changes at the next frame_done.
  - enable=0 written in the same cycle as frame_done in RUN: → IDLE directly.
  - Address register write: takes effect on dma_addr the next cycle, regardless of state.

## Timing
- Reset values:
  - vga_rst=1; all active and shadow config = 0; state IDLE; enable=0; front=A.
  - dma_start, flip_done, running, cfg_pending = 0; counters = 0.
- Register write → shadow/control visible the next cycle. In IDLE, the active outputs update 2 cycles after cfg_write.
- enable write in IDLE → START on the next cycle. dma_start asserts in the first START cycle. vga_rst falls after RST_CYCLES START cycles. running=1 in the following cycle.
- frame_done (registered output from block) → counters, front, and flip_done update on the next edge. dma_start asserts that same cycle with the new dma_addr.
- rst_n asserted mid-frame: all state returns to reset values asynchronously; vga_rst=1 immediately.

## Test plan
- 640×480 modeline (800/525 totals) written in IDLE, then enable=1 → active outputs match; vga_rst low exactly RST_CYCLES=4 cycles after START entry; one dma_start with dma_addr=A.
- Running, 3 frame_done pulses → frame_count=3; 3 further dma_start pulses, all at A.
- Flip written mid-frame → at the next frame_done: flip_done=1 and dma_addr=B in the same cycle as dma_start; a second flip returns to A.
- hdisp written in RUN → cfg_pending=1; outputs unchanged until frame_done; then vga_rst=1, new hdisp, START, new dma_start.
- underrun pulsed twice in one frame, and once together with frame_done of the next frame → underrun_count=2; 300 underrun frames → saturates at 255.
- rst_n low during RUN → vga_rst=1 and counters=0 without a clock edge; after release, IDLE with enable=0.
